// File: rtl/id_ex_operand_stage_pkg.sv
// id_ex_operand_stage_pkg
// Shared definitions for the ID/EX operand stage: base-ISA opcodes, instruction
// field positions, and small decode helpers used by the stage and the
// load-use detector.
package id_ex_operand_stage_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    localparam int RS1_LSB = 15;
    localparam int RS1_MSB = 19;
    localparam int RS2_LSB = 20;
    localparam int RS2_MSB = 24;
    localparam int RD_LSB  = 7;
    localparam int RD_MSB  = 11;

    function automatic logic uses_rs1(input logic [6:0] opc);
        return !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] opc);
        return (opc == OPC_RTYPE || opc == OPC_STORE || opc == OPC_BRANCH);
    endfunction

    function automatic logic is_load(input logic [6:0] opc);
        return (opc == OPC_LOAD);
    endfunction

    // Stores and branches have no destination; a write to x0 is discarded.
    function automatic logic writes_rd(input logic [6:0] opc, input logic [4:0] rd);
        return !(opc == OPC_STORE || opc == OPC_BRANCH) && (rd != 5'd0);
    endfunction

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// id_ex_operand_stage_if
// Bundles every non-clock/reset signal of the operand stage.
//   master : the operand stage (drives rf read addresses, stall, ID/EX register)
//   slave  : the surrounding pipeline (IF/ID latch, register file, WB, EX)
// Parameters: N (datapath width), PC_W (program-counter width).
interface id_ex_operand_stage_if #(
    parameter int N    = 32,
    parameter int PC_W = 32
);
    logic            if_id_valid;
    logic [31:0]     if_id_instr;
    logic [PC_W-1:0] if_id_pc;
    logic            flush;
    logic [4:0]      rf_readreg1;
    logic [4:0]      rf_readreg2;
    logic [N-1:0]    rf_readdata1;
    logic [N-1:0]    rf_readdata2;
    logic            wb_regwrite;
    logic [4:0]      wb_writereg;
    logic [N-1:0]    wb_writedata;
    logic            stall;
    logic            id_ex_valid;
    logic [PC_W-1:0] id_ex_pc;
    logic [31:0]     id_ex_instr;
    logic [N-1:0]    id_ex_rs1_data;
    logic [N-1:0]    id_ex_rs2_data;
    logic [4:0]      id_ex_rs1;
    logic [4:0]      id_ex_rs2;
    logic [4:0]      id_ex_rd;
    logic            id_ex_regwrite;
    logic            id_ex_memread;
    logic [31:0]     stall_count;

    modport master (
        input  if_id_valid, if_id_instr, if_id_pc, flush,
        input  rf_readdata1, rf_readdata2,
        input  wb_regwrite, wb_writereg, wb_writedata,
        output rf_readreg1, rf_readreg2, stall,
        output id_ex_valid, id_ex_pc, id_ex_instr, id_ex_rs1_data, id_ex_rs2_data,
        output id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_regwrite, id_ex_memread,
        output stall_count
    );

    modport slave (
        output if_id_valid, if_id_instr, if_id_pc, flush,
        output rf_readdata1, rf_readdata2,
        output wb_regwrite, wb_writereg, wb_writedata,
        input  rf_readreg1, rf_readreg2, stall,
        input  id_ex_valid, id_ex_pc, id_ex_instr, id_ex_rs1_data, id_ex_rs2_data,
        input  id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_regwrite, id_ex_memread,
        input  stall_count
    );
endinterface

// File: rtl/id_ex_operand_stage_load_use_detect.sv
// load_use_detect
// Combinational load-use hazard detector: flags when the load sitting in ID/EX
// writes a register that the instruction in ID reads.
// Ports:
//   if_id_valid, uses_rs1, uses_rs2, rs1, rs2 : decoded ID instruction
//   ex_valid, ex_memread, ex_rd               : current ID/EX contents
//   hz                                        : hazard present
module load_use_detect (
    input  logic       if_id_valid,
    input  logic       uses_rs1,
    input  logic       uses_rs2,
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       ex_valid,
    input  logic       ex_memread,
    input  logic [4:0] ex_rd,
    output logic       hz
);
    assign hz = ex_valid && ex_memread && (ex_rd != 5'd0) && if_id_valid &&
                ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage
// Decode-side operand stage: drives register-file read addresses, bypasses the
// WB write into the operands (the register file does not forward internally),
// detects load-use hazards and updates the ID/EX register, inserting bubbles
// on stall or flush.
// Ports: clk, rst (synchronous, active-high), bus (id_ex_operand_stage_if.master).
// Build option: ID_EX_STALL_COUNT_EN adds a saturating load-use stall counter
// on bus.stall_count; without it stall_count is tied to 0.
module id_ex_operand_stage
    import id_ex_operand_stage_pkg::*;
#(
    parameter int N    = 32,
    parameter int PC_W = 32
) (
    input logic                   clk,
    input logic                   rst,
    id_ex_operand_stage_if.master bus
);
    logic [6:0]   opc;
    logic [4:0]   rs1;
    logic [4:0]   rs2;
    logic [4:0]   rd;
    logic [N-1:0] op1;
    logic [N-1:0] op2;
    logic         hz;

    assign opc = bus.if_id_instr[6:0];
    assign rs1 = bus.if_id_instr[RS1_MSB:RS1_LSB];
    assign rs2 = bus.if_id_instr[RS2_MSB:RS2_LSB];
    assign rd  = bus.if_id_instr[RD_MSB:RD_LSB];

    assign bus.rf_readreg1 = rs1;
    assign bus.rf_readreg2 = rs2;

    always_comb begin
        op1 = bus.rf_readdata1;
        if (rs1 == 5'd0)
            op1 = '0;
        else if (bus.wb_regwrite && bus.wb_writereg == rs1)
            op1 = bus.wb_writedata;

        op2 = bus.rf_readdata2;
        if (rs2 == 5'd0)
            op2 = '0;
        else if (bus.wb_regwrite && bus.wb_writereg == rs2)
            op2 = bus.wb_writedata;
    end

    load_use_detect u_load_use_detect (
        .if_id_valid (bus.if_id_valid),
        .uses_rs1    (uses_rs1(opc)),
        .uses_rs2    (uses_rs2(opc)),
        .rs1         (rs1),
        .rs2         (rs2),
        .ex_valid    (bus.id_ex_valid),
        .ex_memread  (bus.id_ex_memread),
        .ex_rd       (bus.id_ex_rd),
        .hz          (hz)
    );

    // A flush kills the ID instruction, so holding IF/ID for it is pointless.
    assign bus.stall = hz && !bus.flush;

    always_ff @(posedge clk) begin
        if (rst || bus.flush || hz) begin
            bus.id_ex_valid    <= 1'b0;
            bus.id_ex_pc       <= '0;
            bus.id_ex_instr    <= '0;
            bus.id_ex_rs1_data <= '0;
            bus.id_ex_rs2_data <= '0;
            bus.id_ex_rs1      <= '0;
            bus.id_ex_rs2      <= '0;
            bus.id_ex_rd       <= '0;
            bus.id_ex_regwrite <= 1'b0;
            bus.id_ex_memread  <= 1'b0;
        end else begin
            bus.id_ex_valid    <= bus.if_id_valid;
            bus.id_ex_pc       <= bus.if_id_pc;
            bus.id_ex_instr    <= bus.if_id_instr;
            bus.id_ex_rs1_data <= op1;
            bus.id_ex_rs2_data <= op2;
            bus.id_ex_rs1      <= rs1;
            bus.id_ex_rs2      <= rs2;
            bus.id_ex_rd       <= rd;
            bus.id_ex_regwrite <= bus.if_id_valid && writes_rd(opc, rd);
            bus.id_ex_memread  <= bus.if_id_valid && is_load(opc);
        end
    end

`ifdef ID_EX_STALL_COUNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (bus.stall && stall_cnt != 32'hFFFF_FFFF)
            stall_cnt <= stall_cnt + 32'd1;
    end

    assign bus.stall_count = stall_cnt;
`else
    assign bus.stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage
// Directed scenarios with literal expectations, followed by randomized traffic,
// all compared each cycle against a behavioural model of the ID/EX register.
module tb_id_ex_operand_stage;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    id_ex_operand_stage_if #(.N(32), .PC_W(32)) bus ();

    id_ex_operand_stage #(.N(32), .PC_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Behavioural model of the ID/EX contents
    bit          m_known = 0;
    logic        m_valid, m_regwrite, m_memread;
    logic [31:0] m_pc, m_instr, m_rs1d, m_rs2d, m_cnt;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic        obs_stall;

    localparam logic [31:0] ADD_4_3_2 = {7'd0, 5'd2, 5'd3, 3'd0, 5'd4, 7'b0110011};
    localparam logic [31:0] ADD_4_0_2 = {7'd0, 5'd2, 5'd0, 3'd0, 5'd4, 7'b0110011};
    localparam logic [31:0] LW_5_1    = {12'd0, 5'd1, 3'b010, 5'd5, 7'b0000011};
    localparam logic [31:0] ADD_6_5_7 = {7'd0, 5'd7, 5'd5, 3'd0, 5'd6, 7'b0110011};
    // imm 0x28 puts 5 into the rs1 field bits, so a decoder that ignored the
    // opcode would see a false match against x5.
    localparam logic [31:0] LUI_5     = {20'h00028, 5'd5, 7'b0110111};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit f_uses_rs1(input logic [6:0] o);
        return !(o == 7'h37 || o == 7'h17 || o == 7'h6F);
    endfunction
    function automatic bit f_uses_rs2(input logic [6:0] o);
        return (o == 7'h33 || o == 7'h23 || o == 7'h63);
    endfunction
    function automatic bit f_writes(input logic [6:0] o, input logic [4:0] d);
        return !(o == 7'h23 || o == 7'h63) && d != 0;
    endfunction
    function automatic logic [31:0] f_operand(input logic [4:0] idx, input logic [31:0] rf);
        if (idx == 0) return 32'd0;
        if (bus.wb_regwrite && bus.wb_writereg == idx) return bus.wb_writedata;
        return rf;
    endfunction

    // One clock: inputs already driven by the caller.
    task automatic cycle();
        logic [31:0] ins;
        logic [4:0]  r1, r2, d;
        logic [6:0]  o;
        bit          hz, st;
        ins = bus.if_id_instr;
        o   = ins[6:0];
        r1  = ins[19:15];
        r2  = ins[24:20];
        d   = ins[11:7];
        #1;
        hz = m_valid && m_memread && m_rd != 0 && bus.if_id_valid &&
             ((f_uses_rs1(o) && r1 == m_rd) || (f_uses_rs2(o) && r2 == m_rd));
        st = hz && !bus.flush;
        check("rf_readreg1", 64'(bus.rf_readreg1), 64'(r1));
        check("rf_readreg2", 64'(bus.rf_readreg2), 64'(r2));
        if (m_known) check("stall", 64'(bus.stall), 64'(st));
        obs_stall = bus.stall;

        if (rst || bus.flush || hz) begin
            if (rst) m_cnt = 0;
            else if (st && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            m_valid = 0; m_regwrite = 0; m_memread = 0;
            m_pc = 0; m_instr = 0; m_rs1d = 0; m_rs2d = 0;
            m_rs1 = 0; m_rs2 = 0; m_rd = 0;
            if (rst) m_known = 1;
        end else begin
            m_valid    = bus.if_id_valid;
            m_pc       = bus.if_id_pc;
            m_instr    = ins;
            m_rs1d     = f_operand(r1, bus.rf_readdata1);
            m_rs2d     = f_operand(r2, bus.rf_readdata2);
            m_rs1      = r1;
            m_rs2      = r2;
            m_rd       = d;
            m_regwrite = bus.if_id_valid && f_writes(o, d);
            m_memread  = bus.if_id_valid && o == 7'h03;
        end

        @(posedge clk);
        #1;
        if (m_known) begin
            check("id_ex_valid",    64'(bus.id_ex_valid),    64'(m_valid));
            check("id_ex_pc",       64'(bus.id_ex_pc),       64'(m_pc));
            check("id_ex_instr",    64'(bus.id_ex_instr),    64'(m_instr));
            check("id_ex_rs1_data", 64'(bus.id_ex_rs1_data), 64'(m_rs1d));
            check("id_ex_rs2_data", 64'(bus.id_ex_rs2_data), 64'(m_rs2d));
            check("id_ex_rs1",      64'(bus.id_ex_rs1),      64'(m_rs1));
            check("id_ex_rs2",      64'(bus.id_ex_rs2),      64'(m_rs2));
            check("id_ex_rd",       64'(bus.id_ex_rd),       64'(m_rd));
            check("id_ex_regwrite", 64'(bus.id_ex_regwrite), 64'(m_regwrite));
            check("id_ex_memread",  64'(bus.id_ex_memread),  64'(m_memread));
`ifdef ID_EX_STALL_COUNT_EN
            check("stall_count",    64'(bus.stall_count),    64'(m_cnt));
`else
            check("stall_count",    64'(bus.stall_count),    64'd0);
`endif
        end
    endtask

    task automatic drive(input logic r, input logic v, input logic [31:0] ins,
                         input logic fl);
        rst              = r;
        bus.if_id_valid  = v;
        bus.if_id_instr  = ins;
        bus.if_id_pc     = $urandom;
        bus.flush        = fl;
        bus.rf_readdata1 = $urandom;
        bus.rf_readdata2 = $urandom;
        bus.wb_regwrite  = 1'b0;
        bus.wb_writereg  = 5'd0;
        bus.wb_writedata = 32'd0;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0] opcs [8];
        logic [6:0] o;
        opcs = '{7'h03, 7'h23, 7'h63, 7'h33, 7'h37, 7'h17, 7'h6F, 7'h13};
        o = opcs[$urandom_range(0, 7)];
        return {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                3'($urandom), 5'($urandom_range(0, 7)), o};
    endfunction

    initial begin
        // Reset held two cycles with a valid instruction presented
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, ADD_4_3_2, 0);
            cycle();
            check("reset_valid", 64'(bus.id_ex_valid), 64'd0);
            check("reset_stall", 64'(bus.stall), 64'd0);
            check("reset_instr", 64'(bus.id_ex_instr), 64'd0);
        end

        // WB bypass onto rs1
        drive(0, 1, ADD_4_3_2, 0);
        bus.rf_readdata1 = 32'd5;
        bus.wb_regwrite  = 1;
        bus.wb_writereg  = 5'd3;
        bus.wb_writedata = 32'hAA;
        cycle();
        check("bypass_rs1_data", 64'(bus.id_ex_rs1_data), 64'hAA);
        check("bypass_valid", 64'(bus.id_ex_valid), 64'd1);
        check("bypass_regwrite", 64'(bus.id_ex_regwrite), 64'd1);

        // x0 never takes a bypass value
        drive(0, 1, ADD_4_0_2, 0);
        bus.rf_readdata1 = 32'h77;
        bus.wb_regwrite  = 1;
        bus.wb_writereg  = 5'd0;
        bus.wb_writedata = 32'h55;
        cycle();
        check("x0_rs1_data", 64'(bus.id_ex_rs1_data), 64'd0);

        // Three load-use pairs: one stall cycle each, then the consumer enters
        for (int p = 0; p < 3; p++) begin
            drive(0, 1, LW_5_1, 0);
            cycle();
            check("lw_memread", 64'(bus.id_ex_memread), 64'd1);
            drive(0, 1, ADD_6_5_7, 0);
            cycle();
            check("lu_stall", 64'(obs_stall), 64'd1);
            check("lu_bubble", 64'(bus.id_ex_valid), 64'd0);
            drive(0, 1, ADD_6_5_7, 0);
            cycle();
            check("lu_release_stall", 64'(obs_stall), 64'd0);
            check("lu_release_valid", 64'(bus.id_ex_valid), 64'd1);
            check("lu_release_instr", 64'(bus.id_ex_instr), 64'(ADD_6_5_7));
        end

        // LUI carries no rs1 dependence
        drive(0, 1, LW_5_1, 0);
        cycle();
        drive(0, 1, LUI_5, 0);
        cycle();
        check("lui_no_stall", 64'(obs_stall), 64'd0);
        check("lui_valid", 64'(bus.id_ex_valid), 64'd1);

        // Flush beats the hazard
        drive(0, 1, LW_5_1, 0);
        cycle();
        drive(0, 1, ADD_6_5_7, 1);
        cycle();
        check("flush_stall", 64'(obs_stall), 64'd0);
        check("flush_bubble", 64'(bus.id_ex_valid), 64'd0);
`ifdef ID_EX_STALL_COUNT_EN
        check("stall_count_3", 64'(bus.stall_count), 64'd3);
`else
        check("stall_count_off", 64'(bus.stall_count), 64'd0);
`endif

        // Reset arriving mid-stall
        drive(0, 1, LW_5_1, 0);
        cycle();
        drive(1, 1, ADD_6_5_7, 0);
        cycle();
        check("rst_mid_stall_seen", 64'(obs_stall), 64'd1);
        check("rst_mid_valid", 64'(bus.id_ex_valid), 64'd0);
        drive(0, 1, ADD_6_5_7, 0);
        cycle();
        check("rst_mid_stall_drop", 64'(obs_stall), 64'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0,
                  rand_instr(), $urandom_range(0, 7) == 0);
            bus.wb_regwrite  = $urandom_range(0, 1);
            bus.wb_writereg  = 5'($urandom_range(0, 7));
            bus.wb_writedata = $urandom;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
